// File: rtl/sump_cmd_decoder_if.sv
// SUMP command decoder port bundle.
// UART byte stream in; decoded command and status out.
interface sump_cmd_decoder_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  opcode;
  logic [31:0] command;
  logic        cmd_recv_rx;
  logic        long_cmd;
  logic        busy;
  logic        timeout_err;

  modport master (
    output rx_data, rx_valid,
    input  opcode, command, cmd_recv_rx,
    input  long_cmd, busy, timeout_err
  );

  modport slave (
    input  rx_data, rx_valid,
    output opcode, command, cmd_recv_rx,
    output long_cmd, busy, timeout_err
  );
endinterface

// File: rtl/sump_cmd_decoder.sv
// SUMP command decoder: 1-byte short and 5-byte long
// commands, with an inter-byte timeout on long ones.
module sump_cmd_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input logic               clock,
  input logic               ext_reset_n,
  sump_cmd_decoder_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE, B1, B2, B3, B4
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    op_q, op_d;
  logic [31:0]   cmd_q, cmd_d;
  logic          long_q, long_d;
  logic          recv_q, recv_d;
  logic          busy_q, busy_d;
  logic          to_q, to_d;
  logic [7:0]    pend_q, pend_d;
  logic [23:0]   shadow_q, shadow_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock or negedge ext_reset_n) begin
    if (!ext_reset_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      cmd_q    <= '0;
      long_q   <= 1'b0;
      recv_q   <= 1'b0;
      busy_q   <= 1'b0;
      to_q     <= 1'b0;
      pend_q   <= '0;
      shadow_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cmd_q    <= cmd_d;
      long_q   <= long_d;
      recv_q   <= recv_d;
      busy_q   <= busy_d;
      to_q     <= to_d;
      pend_q   <= pend_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cmd_d    = cmd_q;
    long_d   = long_q;
    recv_d   = 1'b0;
    to_d     = 1'b0;
    pend_d   = pend_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    if (bus.rx_valid) begin
      cnt_d = '0;
      unique case (state_q)
        IDLE: begin
          if (!bus.rx_data[7]) begin
            op_d   = bus.rx_data;
            cmd_d  = '0;
            long_d = 1'b0;
            recv_d = 1'b1;
          end else begin
            pend_d  = bus.rx_data;
            state_d = B1;
          end
        end
        B1: begin
          shadow_d[7:0] = bus.rx_data;
          state_d       = B2;
        end
        B2: begin
          shadow_d[15:8] = bus.rx_data;
          state_d        = B3;
        end
        B3: begin
          shadow_d[23:16] = bus.rx_data;
          state_d         = B4;
        end
        B4: begin
          op_d     = pend_q;
          cmd_d    = {bus.rx_data, shadow_q};
          long_d   = 1'b1;
          recv_d   = 1'b1;
          shadow_d = '0;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      // A byte in the same cycle always beats the timeout
      if (cnt_q == TO_MAX) begin
        state_d  = IDLE;
        shadow_d = '0;
        to_d     = 1'b1;
        cnt_d    = '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    busy_d = (state_d != IDLE);
  end

  assign bus.opcode      = op_q;
  assign bus.command     = cmd_q;
  assign bus.long_cmd    = long_q;
  assign bus.cmd_recv_rx = recv_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = to_q;

endmodule

// File: doc/sump_cmd_decoder.md
SUMP_CMD_DECODER -- requirements
Module: sump_cmd_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 100000, SHALL set the maximum idle clock cycles allowed between bytes of one long command.
REQ-002 Port clock, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port ext_reset_n, input, 1, SHALL be the reset: asynchronous, active-low.
REQ-004 Port rx_data, input, 8, SHALL carry the byte from the UART receiver.
REQ-005 Port rx_valid, input, 1, SHALL qualify rx_data; one byte is accepted per high cycle.
REQ-006 Port opcode, output, 8, SHALL hold the opcode of the last completed command.
REQ-007 Port command, output, 32, SHALL hold the parameter word of the last completed command.
REQ-008 Port cmd_recv_rx, output, 1, SHALL be a one-cycle pulse marking a completed command.
REQ-009 Port long_cmd, output, 1, SHALL be high when the last completed command was a 5-byte command.
REQ-010 Port busy, output, 1, SHALL be high while a long command is partially received.
REQ-011 Port timeout_err, output, 1, SHALL be a one-cycle pulse marking an aborted long command.

Function
REQ-012 States SHALL be IDLE, B1, B2, B3, B4; B1..B4 each await one parameter byte.
REQ-013 In IDLE, a byte with bit7=0 SHALL be a short command: opcode=byte, command=0, long_cmd=0, cmd_recv_rx pulses on the next edge, and the FSM stays in IDLE.
REQ-014 In IDLE, a byte with bit7=1 SHALL be latched as the pending opcode and the FSM SHALL go to B1; no outputs change.
REQ-015 Parameter bytes SHALL be little-endian: B1->bits[7:0], B2->[15:8], B3->[23:16], B4->[31:24], assembled in a shadow register.
REQ-016 On the byte accepted in B4, opcode, command and long_cmd=1 SHALL update on the same edge that sets cmd_recv_rx, and the FSM SHALL return to IDLE; latency is 1 cycle from the last byte.
REQ-017 opcode/command/long_cmd SHALL change only at command completion and SHALL otherwise hold.
REQ-018 cmd_recv_rx SHALL be high for exactly one cycle per completed command, regardless of rx_valid.
REQ-019 busy SHALL equal (state != IDLE), registered.
REQ-020 The timeout counter SHALL clear on every accepted byte, SHALL count only in B1..B4, and SHALL saturate; it is at least 17 bits wide for the default parameter.
REQ-021 When the counter reaches TIMEOUT_CYCLES-1 with no rx_valid, the FSM SHALL return to IDLE, discard the shadow data, and pulse timeout_err for one cycle; the outputs of REQ-017 SHALL be unchanged.
REQ-022 If rx_valid coincides with the timeout cycle, the byte SHALL win and no timeout SHALL occur.
REQ-023 A byte arriving in the same cycle as cmd_recv_rx is high SHALL be decoded normally from IDLE, so back-to-back commands lose no bytes.
REQ-024 The first byte received after a timeout SHALL be decoded as a new opcode.
REQ-025 rx_valid held high for N cycles SHALL be treated as N bytes.

Reset
REQ-026 While ext_reset_n=0: state=IDLE, opcode=0, command=0, long_cmd=0, cmd_recv_rx=0, busy=0, timeout_err=0, shadow=0, counter=0.
REQ-027 Reset asserted mid-command SHALL discard the partial command without a cmd_recv_rx or timeout_err pulse.
REQ-028 After release, the first byte SHALL be decoded from IDLE.

Verification
REQ-029 Byte 0x02 -> next cycle: cmd_recv_rx=1 for 1 cycle, opcode=0x02, command=0, long_cmd=0.
REQ-030 Bytes 0x81,0x11,0x22,0x33,0x44 with gaps -> one cmd_recv_rx pulse after 0x44: opcode=0x81, command=0x44332211, long_cmd=1; busy high from after 0x81 until completion.
REQ-031 Bytes 0xC0,0xAA then silence, TIMEOUT_CYCLES=16 -> timeout_err pulses 16 cycles after 0xAA, busy=0, opcode/command keep prior values; next byte 0x01 -> short command 0x01.
REQ-032 Bytes 0xC1,0x01,0x02 then reset pulse, then 0x05 -> no pulse for 0xC1; a single cmd_recv_rx with opcode=0x05, command=0.
REQ-033 Continuous rx_valid for 6 cycles: 0x80,0x01,0x00,0x00,0x00,0x03 -> pulse with 0x80/0x00000001, then a pulse with 0x03/0, no byte lost.
REQ-034 Byte arriving on exactly the timeout cycle (TIMEOUT_CYCLES=16, gap 15) -> no timeout_err; the command completes normally.
